// File: rtl/board_pkg.sv
// board_pkg: shared geometry, colour codes, FSM states and helpers for the board eliminator
package board_pkg;
   localparam int CELL_W = 3;
   localparam int ROWS = 8;
   localparam int COLS = 8;
   localparam int BOARD_W = ROWS * COLS * CELL_W;
   localparam logic [CELL_W-1:0] EMPTY = 3'd0;
   localparam logic [CELL_W-1:0] INVALID = 3'd7;
   typedef enum logic [2:0] {IDLE, SCAN, CLEAR, FALL, REFILL, DONE} state_t;
   function automatic int cell_idx(input int i, input int j);
      return (COLS * i + j) * CELL_W;
   endfunction
   function automatic logic [15:0] lfsr_step(input logic [15:0] l);
      return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
   endfunction
   // cell k takes three LFSR bits starting at k mod 14, folded into colours 1..6
   function automatic logic [CELL_W-1:0] refill_colour(input logic [15:0] l, input int k);
      logic [2:0] r;
      r = l[k % 14 +: 3];
      return r % 3'd6 + 3'd1;
   endfunction
endpackage

// File: rtl/board_eliminator_line_matcher.sv
// line_matcher: flags every cell of an 8-cell line that sits in a same-colour run of three or more
module line_matcher
   import board_pkg::*;
(
   input  logic [COLS*CELL_W-1:0] cells,
   output logic [COLS-1:0] mask
);
   logic [5:0] hit;
   logic [9:0] hp;
   for (genvar k = 0; k < 6; k++) begin : g_t
      logic [CELL_W-1:0] a, b, c;
      assign a = cells[k*CELL_W +: CELL_W];
      assign b = cells[(k+1)*CELL_W +: CELL_W];
      assign c = cells[(k+2)*CELL_W +: CELL_W];
      assign hit[k] = a != EMPTY && a != INVALID && a == b && a == c;
   end
   assign hp = {2'b00, hit, 2'b00};
   for (genvar k = 0; k < 8; k++) begin : g_m
      assign mask[k] = hp[k+2] | hp[k+1] | hp[k];
   end
endmodule

// File: rtl/board_eliminator.sv
// board_eliminator: scan/clear/gravity/refill loop that settles a match-3 board
module board_eliminator
   import board_pkg::*;
#(
   parameter int MAX_CHAIN = 8,
   parameter bit REFILL_EN = 1'b1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic clk,
   input  logic rst,
   input  logic start,
   input  logic [BOARD_W-1:0] board_in,
   output logic [BOARD_W-1:0] board_out,
   output logic busy,
   output logic done,
   output logic [15:0] score,
   output logic [3:0] chain
);
   state_t state, state_n;
   logic [3:0] cnt;
   logic [63:0] mask, line_bits, scan_mask;
   logic [15:0] lfsr;
   logic [CELL_W-1:0] grid [ROWS][COLS];
   logic [COLS*CELL_W-1:0] line;
   logic [7:0] hits, shift;
   logic [5:0] idx;
   logic [BOARD_W-1:0] cleared, refilled, fallen;
   logic above;
   int tgt;
   logic [16:0] sum;
   always_comb begin
      for (int i = 0; i < ROWS; i++)
         for (int j = 0; j < COLS; j++)
            grid[i][j] = board_out[cell_idx(i, j) +: CELL_W];
   end
   // counter 0..7 selects a row, 8..15 a column; one matcher serves both
   always_comb begin
      line = '0;
      for (int k = 0; k < COLS; k++)
         line[k*CELL_W +: CELL_W] = cnt[3] ? grid[k][cnt[2:0]] : grid[cnt[2:0]][k];
   end
   line_matcher u_match (.cells(line), .mask(hits));
   always_comb begin
      line_bits = '0;
      idx = '0;
      for (int k = 0; k < 8; k++) begin
         idx = cnt[3] ? {3'(k), cnt[2:0]} : {cnt[2:0], 3'(k)};
         line_bits[idx] = hits[k];
      end
   end
   assign scan_mask = mask | line_bits;
   assign sum = {1'b0, score} + 17'($countones(mask));
   always_comb begin
      cleared = board_out;
      refilled = board_out;
      for (int k = 0; k < ROWS*COLS; k++) begin
         if (mask[k]) cleared[k*CELL_W +: CELL_W] = EMPTY;
         if (board_out[k*CELL_W +: CELL_W] == EMPTY) refilled[k*CELL_W +: CELL_W] = refill_colour(lfsr, k);
      end
   end
   // per column: the lowest hole with something above it drops the whole stack above by one row
   always_comb begin
      fallen = board_out;
      shift = '0;
      above = 1'b0;
      tgt = 0;
      for (int j = 0; j < COLS; j++) begin
         above = 1'b0;
         tgt = 0;
         for (int i = 0; i < ROWS; i++) begin
            if (grid[i][j] == EMPTY && above) begin
               shift[j] = 1'b1;
               tgt = i;
            end
            above = above | (grid[i][j] != EMPTY);
         end
         for (int i = 1; i < ROWS; i++)
            if (shift[j] && i <= tgt) fallen[cell_idx(i, j) +: CELL_W] = grid[i-1][j];
         if (shift[j]) fallen[cell_idx(0, j) +: CELL_W] = EMPTY;
      end
   end
   always_comb begin
      state_n = state;
      busy = state != IDLE && state != DONE;
      done = state == DONE;
      case (state)
         IDLE:    state_n = start ? SCAN : IDLE;
         SCAN:    state_n = cnt != 4'd15 ? SCAN : (scan_mask == '0 || chain == 4'(MAX_CHAIN)) ? DONE : CLEAR;
         CLEAR:   state_n = FALL;
         FALL:    state_n = shift == '0 ? REFILL : FALL;
         REFILL:  state_n = SCAN;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         cnt <= '0;
         mask <= '0;
         lfsr <= LFSR_SEED;
         board_out <= '0;
         score <= '0;
         chain <= '0;
      end else begin
         state <= state_n;
         lfsr <= lfsr_step(lfsr);
         cnt <= state == SCAN ? cnt + 4'd1 : 4'd0;
         mask <= state == SCAN ? scan_mask : '0;
         if (state == IDLE && start) begin
            board_out <= board_in;
            score <= '0;
            chain <= '0;
         end
         if (state == CLEAR) begin
            board_out <= cleared;
            score <= sum[16] ? 16'hFFFF : sum[15:0];
            chain <= chain + 4'd1;
         end
         if (state == FALL) board_out <= fallen;
         if (state == REFILL && REFILL_EN) board_out <= refilled;
      end
endmodule

// File: tb/tb_board_eliminator.sv
// tb_board_eliminator: two instances (refill off/on) checked every cycle against a pass-level board model
module tb_board_eliminator;
   typedef struct {
      logic [191:0] b;
      int score;
      int chain;
      int t;
   } res_t;
   logic clk = 0, rst = 1, start = 0;
   logic [191:0] board_in = '0;
   logic [191:0] bo [2];
   logic bsy [2], dn [2];
   logic [15:0] sc [2];
   logic [3:0] ch [2];
   int total = 0, bad = 0, cyc = 0;
   logic [15:0] lf;
   bit active [2];
   int done_at [2];
   logic [191:0] eb [2];
   int es [2], ec [2];
   res_t mr;
   always #5 clk = ~clk;
   board_eliminator #(.REFILL_EN(1'b0)) u0 (.clk(clk), .rst(rst), .start(start), .board_in(board_in),
      .board_out(bo[0]), .busy(bsy[0]), .done(dn[0]), .score(sc[0]), .chain(ch[0]));
   board_eliminator #(.REFILL_EN(1'b1)) u1 (.clk(clk), .rst(rst), .start(start), .board_in(board_in),
      .board_out(bo[1]), .busy(bsy[1]), .done(dn[1]), .score(sc[1]), .chain(ch[1]));
   function automatic int at(int i, int j);
      return (8 * i + j) * 3;
   endfunction
   function automatic logic [15:0] step(logic [15:0] l);
      return l[0] ? (l >> 1) ^ 16'hB400 : l >> 1;
   endfunction
   function automatic logic [63:0] runs(logic [191:0] b);
      logic [63:0] m = '0;
      int c;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 6; j++) begin
            c = b[at(i, j) +: 3];
            if (c != 0 && c != 7 && b[at(i, j + 1) +: 3] == c && b[at(i, j + 2) +: 3] == c) m |= 64'h7 << (8 * i + j);
            c = b[at(j, i) +: 3];
            if (c != 0 && c != 7 && b[at(j + 1, i) +: 3] == c && b[at(j + 2, i) +: 3] == c) m |= 64'h10101 << (8 * j + i);
         end
      return m;
   endfunction
   function automatic bit filled_above(logic [191:0] b, int i, int j);
      for (int k = 0; k < i; k++)
         if (b[at(k, j) +: 3] != 0) return 1;
      return 0;
   endfunction
   // t = cycles from the accepting edge to the edge that raises done; l tracks the LFSR along the way
   function automatic res_t model(logic [191:0] b, logic [15:0] l, bit ren);
      res_t r;
      logic [63:0] m;
      bit moved;
      int hole;
      r.score = 0;
      r.chain = 0;
      r.t = 0;
      while (1) begin
         m = runs(b);
         r.t += 16;
         for (int s = 0; s < 16; s++) l = step(l);
         if (m == 0 || r.chain == 8) break;
         for (int k = 0; k < 64; k++)
            if (m[k]) b[k * 3 +: 3] = 0;
         r.score = r.score + $countones(m) > 65535 ? 65535 : r.score + $countones(m);
         r.chain++;
         r.t++;
         l = step(l);
         do begin
            moved = 0;
            for (int j = 0; j < 8; j++) begin
               hole = -1;
               for (int i = 1; i < 8; i++)
                  if (b[at(i, j) +: 3] == 0 && filled_above(b, i, j)) hole = i;
               if (hole > 0) begin
                  for (int s = hole; s > 0; s--) b[at(s, j) +: 3] = b[at(s - 1, j) +: 3];
                  b[at(0, j) +: 3] = 0;
                  moved = 1;
               end
            end
            r.t++;
            l = step(l);
         end while (moved);
         if (ren)
            for (int k = 0; k < 64; k++)
               if (b[k * 3 +: 3] == 0) b[k * 3 +: 3] = 3'((((l >> (k % 14)) & 16'h7) % 6) + 1);
         r.t++;
         l = step(l);
      end
      r.b = b;
      return r;
   endfunction
   function automatic logic [191:0] cb();
      logic [191:0] b;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) b[at(i, j) +: 3] = 3'(((i + j) % 2) + 1);
      return b;
   endfunction
   function automatic logic [191:0] row7();
      logic [191:0] b = cb();
      for (int j = 0; j < 3; j++) b[at(7, j) +: 3] = 3'd3;
      return b;
   endfunction
   function automatic logic [191:0] gen();
      logic [191:0] b;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) b[at(i, j) +: 3] = j == 4 ? 3'd4 : 3'((i % 6) + 1);
      return b;
   endfunction
   function automatic logic [191:0] lshape();
      logic [191:0] b = cb();
      b[at(5, 0) +: 3] = 3'd3;
      b[at(6, 0) +: 3] = 3'd3;
      b[at(7, 0) +: 3] = 3'd3;
      b[at(7, 1) +: 3] = 3'd3;
      b[at(7, 2) +: 3] = 3'd3;
      return b;
   endfunction
   task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask
   task automatic pulse(input logic [191:0] b);
      board_in = b;
      start = 1;
      @(posedge clk);
      #1 start = 0;
   endtask
   task automatic wait_idle();
      int n = 0;
      while ((bsy[0] || bsy[1] || dn[0] || dn[1]) && n < 3000) begin
         @(posedge clk);
         #1 n++;
      end
      total++;
      if (n >= 3000) begin
         bad++;
         $display("FAIL idle_timeout: still busy after %0d cycles, want idle", n);
      end
   endtask
   always @(posedge clk or posedge rst)
      if (rst) begin
         lf <= 16'hACE1;
         cyc <= 0;
         for (int d = 0; d < 2; d++) begin
            active[d] <= 0;
            done_at[d] <= 0;
            eb[d] <= '0;
            es[d] <= 0;
            ec[d] <= 0;
         end
      end else begin
         lf <= step(lf);
         cyc <= cyc + 1;
         for (int d = 0; d < 2; d++)
            if (start && (!active[d] || cyc + 1 >= done_at[d] + 2)) begin
               mr = model(board_in, step(lf), d == 1);
               active[d] <= 1;
               done_at[d] <= cyc + 1 + mr.t;
               eb[d] <= mr.b;
               es[d] <= mr.score;
               ec[d] <= mr.chain;
            end
      end
   always @(negedge clk)
      if (!rst)
         for (int d = 0; d < 2; d++)
            if (active[d] && cyc < done_at[d]) begin
               chk($sformatf("u%0d_busy", d), bsy[d], 1);
               chk($sformatf("u%0d_done", d), dn[d], 0);
            end else begin
               chk($sformatf("u%0d_busy", d), bsy[d], 0);
               chk($sformatf("u%0d_done", d), dn[d], active[d] && cyc == done_at[d]);
               chk($sformatf("u%0d_board", d), bo[d], eb[d]);
               chk($sformatf("u%0d_score", d), sc[d], es[d]);
               chk($sformatf("u%0d_chain", d), ch[d], ec[d]);
            end
   initial begin
      res_t r;
      logic [191:0] b;
      int n, nb;
      bit full, ok;
      logic [2:0] c;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      r = model(cb(), 16'h1, 0);
      chk("pin_cb_t", r.t, 16);
      chk("pin_cb_score", r.score, 0);
      r = model(row7(), 16'h1, 0);
      chk("pin_row7_t", r.t, 36);
      chk("pin_row7_score", r.score, 3);
      chk("pin_row7_chain", r.chain, 1);
      r = model(gen(), 16'h1, 0);
      chk("pin_gen_score", r.score, 64);
      chk("pin_gen_board", r.b, 192'h0);
      r = model(lshape(), 16'h1, 0);
      chk("pin_l_score", r.score, 5);
      pulse(cb());
      n = 0;
      nb = bsy[0] ? 1 : 0;
      while (!dn[0] && n < 100) begin
         @(posedge clk);
         #1 n++;
         if (bsy[0]) nb++;
      end
      chk("cb_latency", n, 16);
      chk("cb_busy_cycles", nb, 16);
      wait_idle();
      chk("cb_board", bo[0], cb());
      pulse(row7());
      wait_idle();
      chk("row7_score", sc[0], 3);
      chk("row7_chain", ch[0], 1);
      chk("row7_top_empty", bo[0][8:0], 9'h0);
      chk("row7_fell", bo[0][at(7, 0) +: 3], 3'd1);
      pulse(gen());
      wait_idle();
      chk("gen_score", sc[0], 64);
      chk("gen_chain", ch[0], 1);
      chk("gen_board", bo[0], 192'h0);
      pulse(lshape());
      wait_idle();
      chk("l_score", sc[0], 5);
      chk("l_chain", ch[0], 1);
      pulse(gen());
      repeat (17) @(posedge clk);
      #1 rst = 1;
      #1;
      chk("rst_board", bo[0], 192'h0);
      chk("rst_busy", bsy[0], 0);
      chk("rst_done", dn[0], 0);
      @(posedge clk);
      #1 rst = 0;
      n = 0;
      repeat (30) begin
         @(posedge clk);
         #1 if (dn[0] || dn[1]) n++;
      end
      chk("rst_no_done", n, 0);
      for (int it = 0; it < 240; it++) begin
         full = it % 8 != 7;
         for (int k = 0; k < 64; k++) b[k * 3 +: 3] = full ? 3'($urandom_range(1, 6)) : 3'($urandom_range(0, 7));
         pulse(b);
         if ($urandom_range(0, 2) == 0) begin
            repeat ($urandom_range(1, 20)) @(posedge clk);
            #1 pulse(~b);
         end
         wait_idle();
         if (full) begin
            ok = 1;
            for (int k = 0; k < 64; k++) begin
               c = bo[1][k * 3 +: 3];
               if (c < 1 || c > 6) ok = 0;
            end
            chk("colours", ok, 1);
            chk("settled", runs(bo[1]) == 0 || ch[1] == 8, 1);
         end
      end
      pulse(row7());
      n = 0;
      while (!dn[1] && n < 3000) begin
         @(posedge clk);
         #1 n++;
      end
      chk("wait_done1", dn[1], 1);
      pulse(gen());
      chk("ignored_at_done", bsy[1], 0);
      wait_idle();
      pulse(lshape());
      wait_idle();
      chk("restart_score", sc[0], 5);
      chk("restart_chain", ch[0], 1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/board_eliminator.md
Name: board_eliminator

Overview:
Downstream stage of the 8x8 board generator in the match-3 logic. It accepts a 192-bit board (64 cells × 3 bits) and runs a sequential scan → clear → gravity → refill loop until no run of three or more same-coloured cells remains. It then presents the settled board, the cleared-cell score and the cascade count to the display/game-control logic.

Parameters:
MAX_CHAIN, 8, maximum clear passes per start; the loop stops after this many passes even if matches remain.
REFILL_EN, 1, 1 = refill empty cells from the LFSR after gravity; 0 = leave empty cells as 0 (used for deterministic test).
LFSR_SEED, 16'hACE1, reset value of the refill LFSR; must be nonzero.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to process board_in; connected to the generator's if_generated
board_in  in  192  input board; cell (i,j) is at bits [(8*i+j)*3 +: 3]; i = row (0 = top, 7 = bottom), j = column
board_out  out  192  working/settled board; holds its value after done
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when board_out is settled
score  out  16  cells cleared since the last accepted start; saturates at 16'hFFFF
chain  out  4  number of clear passes performed for the last start

Behaviour:
- Reset (asynchronous, any state): state=IDLE; board_out=0, busy=0, done=0, score=0, chain=0; LFSR=LFSR_SEED; match mask and counters cleared. A reset mid-operation aborts the operation with no done pulse.
- Colour encoding: 0 = empty; 1..6 = colours; 7 = invalid. Values 0 and 7 never match.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1. Advances every cycle when not in reset.
- IDLE: on start=1, latch board_in into board_out, clear score/chain/mask, go to SCAN with line counter = 0, busy=1. start is ignored in every state except IDLE.
- SCAN, 16 cycles:
  - Counter 0..7: examine row counter.
  - Counter 8..15: examine column counter−8.
  - Every cell in a maximal run of length ≥3 with equal nonzero, non-7 colour has its bit ORed into a 64-bit mask. Cells in both a horizontal and a vertical run are counted once.
  - After counter 15: if mask=0 or chain=MAX_CHAIN, go to DONE; otherwise go to CLEAR.
- CLEAR, 1 cycle:
  - Every masked cell is set to 0.
  - score += popcount(mask), saturating.
  - chain += 1; mask cleared; go to FALL.
- FALL, ≤8 cycles:
  - Each cycle, in every column independently, find the lowest empty cell that has a nonempty cell above it. Shift every cell above it down one row and set row 0 of that column to 0.
  - If no column needs a shift in a cycle, the board is unchanged and the state goes to REFILL.
- REFILL, 1 cycle:
  - If REFILL_EN=1: each empty cell k = 8*i+j gets colour (((lfsr >> (k mod 14)) & 3'b111) mod 6) + 1.
  - Then go to SCAN with the counter reset to 0.
- DONE, 1 cycle: done=1, busy=0 in that cycle, then return to IDLE. board_out, score and chain are held until the next accepted start.
- Latency for a match-free board: done is high in the 17th cycle after the edge that samples start (16 SCAN + 1 DONE).
- Each pass adds 16 + 1 + (F+1) + 1 cycles, where F = number of shifting fall cycles.

Decomposition:
- Shared package (board_pkg):
  - CELL_W=3, ROWS=8, COLS=8, BOARD_W=192.
  - Colour constants: EMPTY=0, INVALID=7.
  - A cell-index function returning (8*i+j)*3.
  - State encoding: IDLE, SCAN, CLEAR, FALL, REFILL, DONE.
- One sub-module: line_matcher. It is combinational: 8 cells in, 8-bit run≥3 mask out. It is instantiated once and shared by row and column scanning via a multiplexed line select.

Test Plan:
- Match-free checkerboard (colours 1/2 alternating), start pulse → done exactly 17 cycles later; board_out == board_in; score=0; chain=0; busy high for 16 cycles.
- REFILL_EN=0, board of checkerboard with row 7 cols 0..2 = colour 3 and no other runs → row 7 cols 0..2 become 0 and the cells above fall into them; score=3; chain=1; row 0 cols 0..2 = 0.
- REFILL_EN=0, generator pattern (row i colour i%6+1, column 4 colour 4 in every row) → every cell cleared; board_out=0; score=64; chain=1. Also an L-shape cross (horizontal and vertical runs sharing a corner) → the corner is counted once (score=5).
- REFILL_EN=1, random boards, ≥200 starts → board_out contains only colours 1..6. Either no run ≥3 remains, or chain=MAX_CHAIN. score equals the reference-model clear total.
- Assert rst during FALL → board_out=0, busy=0, no done pulse. A start during busy is ignored; the final result is unaffected.
- Start on the same cycle as the done pulse → ignored. The next start in IDLE is accepted, and score/chain restart from 0.
